// File: rtl/subleq_ctrl.sv
// subleq_ctrl: multi-cycle SUBLEQ sequencer (fetch A/B/C, read operands,
// subtract, write back, branch). Single-port memory valid/ready handshake.
// Ports: clk, rst (sync, active-high), start/start_pc, mem_* handshake,
// alu_a/alu_b -> alu_result/alu_zero/alu_negative, pc, busy, halted.
// Optional: define SUBLEQ_RETIRE_CNT_EN to add the 64-bit retired counter.
module subleq_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata,
  output logic [63:0]       alu_a,
  output logic [63:0]       alu_b,
  input  logic [63:0]       alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
`ifdef SUBLEQ_RETIRE_CNT_EN
  output logic [63:0]       retired,
`endif
  output logic              halted
);

  typedef enum logic [2:0] {
    HALT, FETCH_A, FETCH_B, FETCH_C,
    READ_A, READ_B, EXEC, WRITE
  } state_t;

  state_t state, state_n;

  // Only the address bits of A/B/C are ever used, plus C's halt bit.
  logic [ADDR_W-1:0] ra, rb, rc;
  logic              rc_h;
  logic [63:0]       opa, opb, res;
  logic              zf, nf;
  logic              acc, taken, hlt;

  assign acc   = mem_req & mem_ready;
  assign taken = zf | nf;
  assign hlt   = taken & rc_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HALT;
      busy   <= 1'b0;
      halted <= 1'b1;
    end else begin
      state  <= state_n;
      busy   <= (state_n != HALT);
      halted <= (state_n == HALT);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HALT:    if (start) state_n = FETCH_A;
      FETCH_A: if (mem_ready) state_n = FETCH_B;
      FETCH_B: if (mem_ready) state_n = FETCH_C;
      FETCH_C: if (mem_ready) state_n = READ_A;
      READ_A:  if (mem_ready) state_n = READ_B;
      READ_B:  if (mem_ready) state_n = EXEC;
      EXEC:    state_n = WRITE;
      WRITE:   if (mem_ready) state_n = hlt ? HALT : FETCH_A;
      default: state_n = HALT;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      FETCH_A: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      FETCH_B: begin
        mem_req  = 1'b1;
        mem_addr = pc + ADDR_W'(1);
      end
      FETCH_C: begin
        mem_req  = 1'b1;
        mem_addr = pc + ADDR_W'(2);
      end
      READ_A: begin
        mem_req  = 1'b1;
        mem_addr = ra;
      end
      READ_B: begin
        mem_req  = 1'b1;
        mem_addr = rb;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = rb;
        mem_wdata = res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      rc_h  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      zf    <= 1'b0;
      nf    <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
    end else begin
      if (state == HALT && start)
        pc <= start_pc;
      if (state == FETCH_A && acc)
        ra <= mem_rdata[ADDR_W-1:0];
      if (state == FETCH_B && acc)
        rb <= mem_rdata[ADDR_W-1:0];
      if (state == FETCH_C && acc) begin
        rc   <= mem_rdata[ADDR_W-1:0];
        rc_h <= mem_rdata[63];
      end
      if (state == READ_A && acc)
        opa <= mem_rdata;
      // ALU inputs change only on entry to EXEC.
      if (state == READ_B && acc) begin
        opb   <= mem_rdata;
        alu_a <= opa;
        alu_b <= mem_rdata;
      end
      if (state == EXEC) begin
        res <= alu_result;
        zf  <= alu_zero;
        nf  <= alu_negative;
      end
      // On a halting branch pc keeps the faulting address.
      if (state == WRITE && acc && !hlt)
        pc <= taken ? rc : pc + ADDR_W'(3);
    end
  end

`ifdef SUBLEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      retired <= '0;
    else if (state == WRITE && acc)
      retired <= retired + 64'd1;
  end
`endif

endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: random and directed programs against an
// instruction-level SUBLEQ model, with a stalling memory responder.
module tb_subleq_ctrl;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_ready = 1'b0;
  logic [63:0]   mem_rdata;
  logic [63:0]   alu_a, alu_b, alu_result;
  logic          alu_zero, alu_negative;
  logic [AW-1:0] pc;
  logic          busy, halted;
`ifdef SUBLEQ_RETIRE_CNT_EN
  logic [63:0]   retired;
`endif

  logic [63:0] mem  [0:65535];
  logic [63:0] rmem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  int max_stall = 0;
  bit hold_wr   = 0;
  int cyc = 0, wr_cnt = 0, wr_cyc = 0, start_cyc = 0;
  int left = 0;
  bit armed = 0, stl = 0;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [63:0]   s_wdata;

  subleq_ctrl #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_pc(start_pc),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_result(alu_result),
    .alu_zero(alu_zero),
    .alu_negative(alu_negative),
    .pc(pc),
    .busy(busy),
`ifdef SUBLEQ_RETIRE_CNT_EN
    .retired(retired),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata    = mem[mem_addr];
  assign alu_result   = alu_b - alu_a;
  assign alu_zero     = (alu_result == 64'd0);
  assign alu_negative = alu_result[63];

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder: commits writes, randomizes stalls, checks holds.
  always @(posedge clk) begin
    cyc++;
    check("excl", 128'(busy & halted), 128'(0));
    if (stl)
      check("hold", {mem_req, mem_we, mem_addr, mem_wdata},
            {1'b1, s_we, s_addr, s_wdata});
    stl     = mem_req && !mem_ready && !rst;
    s_we    = mem_we;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    if (start && !rst && halted)
      start_cyc = cyc;
    if (mem_req && mem_ready) begin
      armed = 0;
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_cnt++;
        wr_cyc = cyc;
      end
    end
    #1;
    if (!mem_req) begin
      armed     = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end else begin
      if (!armed) begin
        armed = 1;
        left  = int'($urandom_range(0, max_stall));
      end
      if (hold_wr && mem_we) begin
        mem_ready = 1'b0;
      end else begin
        mem_ready = (left == 0);
        if (left > 0) left--;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = '0;
      rmem[i] = '0;
    end
  endtask

  task automatic put(input logic [15:0] a, input logic [63:0] v);
    mem[a]  = v;
    rmem[a] = v;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Instruction-level reference: up to k instructions or a halt.
  task automatic model(input logic [15:0] spc, input int k,
                       output int n, output logic [15:0] epc,
                       output bit eh);
    logic [15:0] p, p1, p2;
    logic [63:0] a, b, c, r;
    p  = spc;
    n  = 0;
    eh = 0;
    while (n < k && !eh) begin
      p1 = p + 16'd1;
      p2 = p + 16'd2;
      a  = rmem[p];
      b  = rmem[p1];
      c  = rmem[p2];
      r  = rmem[b[15:0]] - rmem[a[15:0]];
      rmem[b[15:0]] = r;
      n++;
      if ($signed(r) <= 0) begin
        if (c[63]) eh = 1;
        else p = c[15:0];
      end else begin
        p = p + 16'd3;
      end
    end
    epc = p;
  endtask

  task automatic run(input string tag, input logic [15:0] spc,
                     input int k, input int stall, input bit poke);
    int n, base, t, bad;
    logic [15:0] epc;
    bit eh;
    max_stall = stall;
    model(spc, k, n, epc, eh);
    base = wr_cnt;
    start_pc = spc;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    if (poke) begin
      @(posedge clk);
      #2;
      start_pc = spc ^ 16'h0040;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      check({tag, ".ign"}, 128'(pc), 128'(spc));
    end
    t = 0;
    while (wr_cnt - base < n && t < 4000) begin
      @(posedge clk);
      #2;
      t++;
    end
    check({tag, ".nwr"}, 128'(wr_cnt - base), 128'(n));
    check({tag, ".pc"}, 128'(pc), 128'(epc));
    check({tag, ".halted"}, 128'(halted), 128'(eh));
    check({tag, ".busy"}, 128'(busy), 128'(!eh));
    if (stall == 0)
      check({tag, ".cyc"}, 128'(wr_cyc - start_cyc), 128'(7 * n));
    bad = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== rmem[i]) bad++;
    check({tag, ".img"}, 128'(bad), 128'(0));
  endtask

  task automatic prog1(input logic [63:0] m10);
    clear_mem();
    put(16'd0, 64'd10);
    put(16'd1, 64'd11);
    put(16'd2, 64'd3);
    put(16'd10, m10);
    put(16'd11, 64'd7);
  endtask

  initial begin
    int base, t;
    rst = 1'b1;
    start = 1'b0;
    start_pc = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst.req", 128'(mem_req), 128'(0));
    check("rst.we", 128'(mem_we), 128'(0));
    check("rst.addr", 128'(mem_addr), 128'(0));
    check("rst.wdata", 128'(mem_wdata), 128'(0));
    check("rst.alu_a", 128'(alu_a), 128'(0));
    check("rst.alu_b", 128'(alu_b), 128'(0));
    check("rst.busy", 128'(busy), 128'(0));
    check("rst.halted", 128'(halted), 128'(1));
    check("rst.pc", 128'(pc), 128'(0));

    prog1(64'd5);
    run("nt", 16'd0, 1, 0, 0);
    check("nt.m11", 128'(mem[11]), 128'(2));

    do_reset();
    prog1(64'd7);
    run("zero", 16'd0, 1, 0, 1);
    check("zero.m11", 128'(mem[11]), 128'(0));

    do_reset();
    prog1(64'd9);
    run("neg", 16'd0, 1, 0, 0);
    check("neg.m11", 128'(mem[11]), 128'(64'hFFFF_FFFF_FFFF_FFFE));

    do_reset();
    clear_mem();
    put(16'd0, 64'd10);
    put(16'd1, 64'd10);
    put(16'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    put(16'd10, 64'd123);
    put(16'd6, 64'd20);
    put(16'd7, 64'd20);
    put(16'd8, 64'h8000_0000_0000_0000);
    put(16'd20, 64'd55);
    run("halt", 16'd0, 5, 0, 0);
    check("halt.m10", 128'(mem[10]), 128'(0));
    run("resume", 16'd6, 5, 0, 0);
    check("resume.m20", 128'(mem[20]), 128'(0));

    do_reset();
    clear_mem();
    put(16'hFFFE, 64'd10);
    put(16'hFFFF, 64'd11);
    put(16'h0000, 64'd3);
    put(16'd10, 64'd5);
    put(16'd11, 64'd7);
    run("wrap", 16'hFFFE, 1, 0, 0);

    do_reset();
    clear_mem();
    put(16'd0, 64'd10);
    put(16'd1, 64'd11);
    put(16'd2, 64'd3);
    put(16'd10, 64'd5);
    put(16'd11, 64'd7);
    put(16'd3, 64'd20);
    put(16'd4, 64'd21);
    put(16'd5, 64'd6);
    put(16'd20, 64'd1);
    put(16'd21, 64'd5);
    put(16'd6, 64'd22);
    put(16'd7, 64'd22);
    put(16'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    put(16'd22, 64'd9);
    run("p3", 16'd0, 10, 2, 0);
`ifdef SUBLEQ_RETIRE_CNT_EN
    check("p3.retired", 128'(retired), 128'(3));
    do_reset();
    check("p3.retired_rst", 128'(retired), 128'(0));
`endif

    do_reset();
    prog1(64'd5);
    max_stall = 0;
    hold_wr = 1;
    start_pc = '0;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    t = 0;
    while (!(mem_req && mem_we) && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("rstw.reach", 128'(mem_req && mem_we), 128'(1));
    repeat (2) @(posedge clk);
    #2;
    base = wr_cnt;
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rstw.req", 128'(mem_req), 128'(0));
    check("rstw.we", 128'(mem_we), 128'(0));
    check("rstw.addr", 128'(mem_addr), 128'(0));
    check("rstw.wdata", 128'(mem_wdata), 128'(0));
    check("rstw.alu_a", 128'(alu_a), 128'(0));
    check("rstw.alu_b", 128'(alu_b), 128'(0));
    check("rstw.busy", 128'(busy), 128'(0));
    check("rstw.halted", 128'(halted), 128'(1));
    check("rstw.pc", 128'(pc), 128'(0));
    rst = 1'b0;
    hold_wr = 0;
    repeat (20) @(posedge clk);
    #2;
    check("rstw.nwr", 128'(wr_cnt - base), 128'(0));
    check("rstw.m11", 128'(mem[11]), 128'(7));

    for (int r = 0; r < 12; r++) begin
      do_reset();
      clear_mem();
      for (int i = 0; i < 21; i++) begin
        put(16'(3 * i), 64'(64 + $urandom_range(0, 31)));
        if ($urandom_range(0, 7) == 0)
          put(16'(3 * i + 1), 64'($urandom_range(0, 62)));
        else
          put(16'(3 * i + 1), 64'(64 + $urandom_range(0, 31)));
        if ($urandom_range(0, 9) == 0)
          put(16'(3 * i + 2), 64'hFFFF_FFFF_FFFF_FFF0);
        else
          put(16'(3 * i + 2), 64'(3 * $urandom_range(0, 20)));
      end
      for (int i = 64; i < 96; i++)
        put(16'(i), 64'($urandom_range(0, 40)) - 64'd20);
      run("rnd", 16'd0, 30, (r % 3 == 0) ? 0 : 3, r == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
